// File: rtl/cross_bar_pkg.sv
// Shared crossbar types: address/data widths, bus word types and request command encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cross_bar_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // Request command: read or write
  typedef logic cmd_t;
  localparam cmd_t CMD_RD = 1'b0;
  localparam cmd_t CMD_WR = 1'b1;

endpackage

// File: rtl/cross_bar_slave_mem_if.sv
// Crossbar master->slave request/response bundle seen at one slave port.
// Latency: n/a (wires only).
// Backpressure: sl_ack from the slave qualifies sl_req; sl_resp is a one-cycle pulse with no backpressure.
// Signals: sl_req/sl_addr/sl_cmd/sl_wdata (master->slave), sl_ack/sl_resp/sl_rdata (slave->master).
interface cross_bar_slave_mem_if;
  import cross_bar_pkg::*;

  logic  sl_req;
  addr_t sl_addr;
  cmd_t  sl_cmd;
  data_t sl_wdata;
  logic  sl_ack;
  logic  sl_resp;
  data_t sl_rdata;

  modport master (
    output sl_req, sl_addr, sl_cmd, sl_wdata,
    input  sl_ack, sl_resp, sl_rdata
  );

  modport slave (
    input  sl_req, sl_addr, sl_cmd, sl_wdata,
    output sl_ack, sl_resp, sl_rdata
  );

endinterface

// File: rtl/cross_bar_slave_rsp_pipe.sv
// Valid/data delay line carrying read data from the RAM sample point to the response port.
// Latency: DEPTH cycles from in_vld to out_vld.
// Backpressure: none; every stage advances every cycle.
// Ports: clk, rst (async, active-high, clears valids only), in_vld/in_data, out_vld/out_data.
module cross_bar_slave_rsp_pipe #(
  parameter int  DEPTH  = 2,
  parameter type data_t = logic [31:0]
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_vld,
  input  data_t in_data,
  output logic  out_vld,
  output data_t out_data
);

  logic [DEPTH-1:0] vld;
  data_t            dat [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= in_vld;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // Data stages carry no reset; they are only meaningful alongside their valid bit.
  always_ff @(posedge clk) begin
    dat[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) begin
      dat[i] <= dat[i-1];
    end
  end

  assign out_vld  = vld[DEPTH-1];
  assign out_data = dat[DEPTH-1];

endmodule

// File: rtl/cross_bar_slave_mem.sv
// Memory-backed crossbar slave: writes land in RAM, reads return in order after RD_LATENCY cycles.
// Latency: write 0 (same edge as ack); read response exactly RD_LATENCY cycles after the ack cycle.
// Backpressure: sl_ack drops while stall_i is high or when OUTST_N reads are already outstanding.
// Ports: clk, rst (async, active-high), stall_i (forces sl_ack low), bus (slave modport of the request bundle).
module cross_bar_slave_mem
  import cross_bar_pkg::*;
#(
  parameter int MEM_DEPTH  = 256,
  parameter int RD_LATENCY = 2,
  parameter int OUTST_N    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  cross_bar_slave_mem_if.slave  bus
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(OUTST_N + 1);
  localparam logic [CNT_W-1:0] OUTST_MAX = CNT_W'(OUTST_N);

  data_t            mem [MEM_DEPTH];
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] outst_cnt;
  logic             xfer;
  logic             wr_xfer;
  logic             rd_xfer;
  logic             rsp_vld;
  data_t            rsp_data;
  data_t            rdata_hold;

  // Word index only; byte-lane bits and bits above the RAM range alias.
  assign idx = bus.sl_addr[IDX_W+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.sl_addr[ADDR_W-1:IDX_W+2], bus.sl_addr[1:0]};

  // No lookahead on a same-cycle response: a full counter blocks reads even if a slot frees now.
  assign bus.sl_ack = bus.sl_req & ~stall_i &
                      ((bus.sl_cmd == CMD_WR) | (outst_cnt < OUTST_MAX));
  assign xfer    = bus.sl_req & bus.sl_ack;
  assign wr_xfer = xfer & (bus.sl_cmd == CMD_WR);
  assign rd_xfer = xfer & (bus.sl_cmd == CMD_RD);

  always_ff @(posedge clk) begin
    if (wr_xfer) begin
      mem[idx] <= bus.sl_wdata;
    end
  end

  // RAM read is captured into stage 0 at the acking edge, so later writes cannot alter it.
  cross_bar_slave_rsp_pipe #(
    .DEPTH  (RD_LATENCY),
    .data_t (data_t)
  ) u_rsp_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_xfer),
    .in_data  (mem[idx]),
    .out_vld  (rsp_vld),
    .out_data (rsp_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst_cnt <= '0;
    end else begin
      case ({rd_xfer, rsp_vld})
        2'b10:   outst_cnt <= outst_cnt + CNT_W'(1);
        2'b01:   outst_cnt <= outst_cnt - CNT_W'(1);
        default: outst_cnt <= outst_cnt;
      endcase
    end
  end

  // Keeps the last delivered word visible between pulses without adding a register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_hold <= '0;
    end else if (rsp_vld) begin
      rdata_hold <= rsp_data;
    end
  end

  assign bus.sl_resp  = rsp_vld;
  assign bus.sl_rdata = rsp_vld ? rsp_data : rdata_hold;

endmodule

// File: tb/tb_cross_bar_slave_mem.sv
module tb_cross_bar_slave_mem;
  import cross_bar_pkg::*;

  logic clk;
  logic rst;
  logic stall_a;
  logic stall_b;

  cross_bar_slave_mem_if bus_a ();
  cross_bar_slave_mem_if bus_b ();

  cross_bar_slave_mem #(.MEM_DEPTH(256), .RD_LATENCY(2), .OUTST_N(4)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall_a),
    .bus     (bus_a.slave)
  );

  cross_bar_slave_mem #(.MEM_DEPTH(256), .RD_LATENCY(1), .OUTST_N(1)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall_b),
    .bus     (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        req;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        exp_ack;
    logic        exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic req, input logic cmd, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic stall, input logic exp_ack,
                     input logic exp_resp, input logic [31:0] exp_rdata);
    vec_t v;
    v.req = req; v.cmd = cmd; v.addr = addr; v.wdata = wdata; v.stall = stall;
    v.exp_ack = exp_ack; v.exp_resp = exp_resp; v.exp_rdata = exp_rdata;
    tbl.push_back(v);
  endtask

  task automatic drive_a(input logic req, input logic cmd, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bus_a.sl_req   = req;
    bus_a.sl_cmd   = cmd;
    bus_a.sl_addr  = addr;
    bus_a.sl_wdata = wdata;
  endtask

  task automatic drive_b(input logic req, input logic cmd, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bus_b.sl_req   = req;
    bus_b.sl_cmd   = cmd;
    bus_b.sl_addr  = addr;
    bus_b.sl_wdata = wdata;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stall_a = 1'b0;
    stall_b = 1'b0;
    drive_a(1'b0, CMD_RD, 32'h0, 32'h0);
    drive_b(1'b0, CMD_RD, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    @(negedge clk);
    chk("rst_resp_a",  {31'h0, bus_a.sl_resp}, 32'h0);
    chk("rst_rdata_a", bus_a.sl_rdata, 32'h0);
    chk("rst_resp_b",  {31'h0, bus_b.sl_resp}, 32'h0);
    chk("rst_cnt_a",   32'(dut_a.outst_cnt), 32'h0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Table: write/read latency, read-before-write ordering, aliasing, stall, rdata hold.
    add(1, CMD_WR, 32'h10,  32'hDEADBEEF, 0, 1, 0, 32'h0);
    add(1, CMD_RD, 32'h10,  32'h0,        0, 1, 0, 32'h0);
    add(0, CMD_RD, 32'h0,   32'h0,        0, 0, 0, 32'h0);
    add(0, CMD_RD, 32'h0,   32'h0,        0, 0, 1, 32'hDEADBEEF);
    add(1, CMD_WR, 32'h20,  32'h1,        0, 1, 0, 32'hDEADBEEF);
    add(1, CMD_RD, 32'h20,  32'h0,        0, 1, 0, 32'hDEADBEEF);
    add(1, CMD_WR, 32'h20,  32'h5,        0, 1, 0, 32'hDEADBEEF);
    add(1, CMD_RD, 32'h20,  32'h0,        0, 1, 1, 32'h1);
    add(0, CMD_RD, 32'h0,   32'h0,        0, 0, 0, 32'h1);
    add(0, CMD_RD, 32'h0,   32'h0,        0, 0, 1, 32'h5);
    add(1, CMD_WR, 32'h0,   32'hA,        0, 1, 0, 32'h5);
    add(1, CMD_RD, 32'h400, 32'h0,        0, 1, 0, 32'h5);
    add(1, CMD_RD, 32'h3,   32'h0,        0, 1, 0, 32'h5);
    add(0, CMD_RD, 32'h0,   32'h0,        0, 0, 1, 32'hA);
    add(0, CMD_RD, 32'h0,   32'h0,        0, 0, 1, 32'hA);
    for (int i = 0; i < 5; i++) add(1, CMD_WR, 32'h30, 32'h77, 1, 0, 0, 32'hA);
    add(1, CMD_WR, 32'h30,  32'h77,       0, 1, 0, 32'hA);
    add(1, CMD_RD, 32'h30,  32'h0,        0, 1, 0, 32'hA);
    add(1, CMD_RD, 32'h10,  32'h0,        0, 1, 0, 32'hA);
    add(0, CMD_RD, 32'h0,   32'h0,        0, 0, 1, 32'h77);
    add(0, CMD_RD, 32'h0,   32'h0,        0, 0, 1, 32'hDEADBEEF);
    add(0, CMD_RD, 32'h0,   32'h0,        0, 0, 0, 32'hDEADBEEF);

    foreach (tbl[i]) begin
      drive_a(tbl[i].req, tbl[i].cmd, tbl[i].addr, tbl[i].wdata);
      stall_a = tbl[i].stall;
      @(negedge clk);
      chk($sformatf("tbl%0d_ack", i),   {31'h0, bus_a.sl_ack},  {31'h0, tbl[i].exp_ack});
      chk($sformatf("tbl%0d_resp", i),  {31'h0, bus_a.sl_resp}, {31'h0, tbl[i].exp_resp});
      chk($sformatf("tbl%0d_rdata", i), bus_a.sl_rdata, tbl[i].exp_rdata);
      next_cycle();
    end
    stall_a = 1'b0;
    drive_a(1'b0, CMD_RD, 32'h0, 32'h0);

    // Back-to-back reads, OUTST_N=4 / RD_LATENCY=2: fill 8 words first.
    for (int k = 0; k < 8; k++) begin
      drive_a(1'b1, CMD_WR, 32'h40 + 32'(4 * k), 32'h100 + 32'(k));
      @(negedge clk);
      chk($sformatf("b2b_wr%0d_ack", k), {31'h0, bus_a.sl_ack}, 32'h1);
      next_cycle();
    end
    for (int j = 0; j < 10; j++) begin
      if (j < 8) drive_a(1'b1, CMD_RD, 32'h40 + 32'(4 * j), 32'h0);
      else       drive_a(1'b0, CMD_RD, 32'h0, 32'h0);
      @(negedge clk);
      chk($sformatf("b2b%0d_ack", j),  {31'h0, bus_a.sl_ack},  (j < 8) ? 32'h1 : 32'h0);
      chk($sformatf("b2b%0d_resp", j), {31'h0, bus_a.sl_resp}, (j >= 2) ? 32'h1 : 32'h0);
      if (j >= 2) chk($sformatf("b2b%0d_rdata", j), bus_a.sl_rdata, 32'h100 + 32'(j - 2));
      next_cycle();
    end
    drive_a(1'b0, CMD_RD, 32'h0, 32'h0);

    // OUTST_N=1 / RD_LATENCY=1: reads held until acked give ack 1,0,1,0...
    for (int k = 0; k < 4; k++) begin
      drive_b(1'b1, CMD_WR, 32'h40 + 32'(4 * k), 32'h200 + 32'(k));
      @(negedge clk);
      chk($sformatf("lim_wr%0d_ack", k), {31'h0, bus_b.sl_ack}, 32'h1);
      next_cycle();
    end
    begin
      int r;
      logic exp_ack;
      r = 0;
      for (int j = 0; j < 8; j++) begin
        if (r < 4) drive_b(1'b1, CMD_RD, 32'h40 + 32'(4 * r), 32'h0);
        else       drive_b(1'b0, CMD_RD, 32'h0, 32'h0);
        exp_ack = (j % 2 == 0) && (r < 4);
        @(negedge clk);
        chk($sformatf("lim%0d_ack", j),  {31'h0, bus_b.sl_ack},  {31'h0, exp_ack});
        chk($sformatf("lim%0d_resp", j), {31'h0, bus_b.sl_resp}, (j % 2 == 1) ? 32'h1 : 32'h0);
        if (j % 2 == 1) chk($sformatf("lim%0d_rdata", j), bus_b.sl_rdata, 32'h200 + 32'((j - 1) / 2));
        if (exp_ack) r++;
        next_cycle();
      end
    end
    drive_b(1'b0, CMD_RD, 32'h0, 32'h0);

    // Reset with two reads in flight: no response may escape, written data survives.
    drive_a(1'b1, CMD_RD, 32'h10, 32'h0);
    @(negedge clk);
    chk("mid_rd0_ack", {31'h0, bus_a.sl_ack}, 32'h1);
    next_cycle();
    drive_a(1'b1, CMD_RD, 32'h30, 32'h0);
    @(negedge clk);
    chk("mid_rd1_ack", {31'h0, bus_a.sl_ack}, 32'h1);
    next_cycle();
    drive_a(1'b0, CMD_RD, 32'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_resp",  {31'h0, bus_a.sl_resp}, 32'h0);
    chk("mid_rst_rdata", bus_a.sl_rdata, 32'h0);
    chk("mid_rst_cnt",   32'(dut_a.outst_cnt), 32'h0);
    next_cycle();
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_resp", j), {31'h0, bus_a.sl_resp}, 32'h0);
      next_cycle();
    end
    drive_a(1'b1, CMD_RD, 32'h30, 32'h0);
    @(negedge clk);
    chk("post_rd0_ack", {31'h0, bus_a.sl_ack}, 32'h1);
    next_cycle();
    drive_a(1'b1, CMD_RD, 32'h10, 32'h0);
    @(negedge clk);
    chk("post_rd1_ack", {31'h0, bus_a.sl_ack}, 32'h1);
    next_cycle();
    drive_a(1'b0, CMD_RD, 32'h0, 32'h0);
    @(negedge clk);
    chk("post_rd0_resp",  {31'h0, bus_a.sl_resp}, 32'h1);
    chk("post_rd0_rdata", bus_a.sl_rdata, 32'h77);
    next_cycle();
    @(negedge clk);
    chk("post_rd1_resp",  {31'h0, bus_a.sl_resp}, 32'h1);
    chk("post_rd1_rdata", bus_a.sl_rdata, 32'hDEADBEEF);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
